// File: rtl/uart_pkg.sv
// +------------------------------------------------------------------+
// | uart_pkg : UART timing defaults, FSM state types, frame geometry  |
// | Option: UART_PARITY_EN adds an odd parity bit.  Rev 1.0           |
// +------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int DEF_CLK_FREQ_HZ  = 100_000_000;
  localparam int DEF_BAUD         = 9600;
  localparam int DEF_CLKS_PER_BIT = DEF_CLK_FREQ_HZ / DEF_BAUD;

`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // Bits between start and stop: data plus the optional parity bit.
  localparam int SHIFT_BITS = FRAME_BITS - 2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_phy_if.sv
// +------------------------------------------------------------------+
// | uart_phy_if : fabric-side byte interface of the UART PHY          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

interface uart_phy_if;

  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [7:0] data_out;
  logic       rx_busy;
  logic       done;

  modport slave (
    input  tx_start, tx_data,
    output tx_busy, data_out, rx_busy, done
  );

  modport master (
    output tx_start, tx_data,
    input  tx_busy, data_out, rx_busy, done
  );

endinterface

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// +------------------------------------------------------------------+
// | uart_bit_timer : bit-period down-counter with tick and half load  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk_100Mhz,
  input  logic rst_n,
  input  logic en,
  input  logic load,
  input  logic load_half,
  output logic tick
);

  localparam int c_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_W-1:0] c_FULL = c_W'(CLKS_PER_BIT - 1);
  localparam logic [c_W-1:0] c_HALF = c_W'(CLKS_PER_BIT / 2 - 1);

  logic [c_W-1:0] r_count;

  // Free-runs while enabled, reloading a full period on every tick.
  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_half ? c_HALF : c_FULL;
    end else if (en) begin
      r_count <= (r_count == '0) ? c_FULL : r_count - c_W'(1);
    end
  end

  assign tick = en && !load && (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/uart_phy.sv
// +------------------------------------------------------------------+
// | uart_phy : full-duplex UART PHY, independent TX and RX engines    |
// | Option: UART_PARITY_EN (odd parity after D7).  Rev 1.0            |
// +------------------------------------------------------------------+
`default_nettype none

module uart_phy
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = DEF_CLK_FREQ_HZ,
  parameter int BAUD         = DEF_BAUD,
  parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD
) (
  input  logic       clk_100Mhz,
  input  logic       rst_n,
  uart_phy_if.slave  bus,
  output logic       tx,
  input  logic       rx
);

  localparam logic [3:0] c_LAST_IDX = 4'(SHIFT_BITS - 1);

  tx_state_t             r_tx_state;
  logic                  r_tx_start_d;
  logic                  r_tx;
  logic [SHIFT_BITS-1:0] r_tx_shift;
  logic [3:0]            r_tx_idx;
  logic                  w_tx_accept;
  logic                  w_tx_run;
  logic                  w_tx_tick;

  assign w_tx_accept = bus.tx_start && !r_tx_start_d && (r_tx_state == TX_IDLE);
  assign w_tx_run    = (r_tx_state != TX_IDLE);
  assign bus.tx_busy = w_tx_run || w_tx_accept;
  assign tx          = r_tx;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk_100Mhz (clk_100Mhz),
    .rst_n      (rst_n),
    .en         (w_tx_run),
    .load       (w_tx_accept),
    .load_half  (1'b0),
    .tick       (w_tx_tick)
  );

  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state   <= TX_IDLE;
      r_tx_start_d <= 1'b0;
      r_tx         <= 1'b1;
      r_tx_shift   <= '0;
      r_tx_idx     <= '0;
    end else begin
      r_tx_start_d <= bus.tx_start;
      case (r_tx_state)
        TX_IDLE: if (w_tx_accept) begin
`ifdef UART_PARITY_EN
          r_tx_shift <= {~(^bus.tx_data), bus.tx_data};
`else
          r_tx_shift <= bus.tx_data;
`endif
          r_tx       <= 1'b0;
          r_tx_state <= TX_START;
        end
        TX_START: if (w_tx_tick) begin
          r_tx       <= r_tx_shift[0];
          r_tx_shift <= r_tx_shift >> 1;
          r_tx_idx   <= '0;
          r_tx_state <= TX_DATA;
        end
        TX_DATA: if (w_tx_tick) begin
          if (r_tx_idx == c_LAST_IDX) begin
            r_tx       <= 1'b1;
            r_tx_state <= TX_STOP;
          end else begin
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_idx   <= r_tx_idx + 4'd1;
          end
        end
        TX_STOP: if (w_tx_tick) r_tx_state <= TX_IDLE;
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  rx_state_t             r_rx_state;
  logic                  r_rx_meta;
  logic                  r_rx_sync;
  logic                  r_rx_prev;
  logic [SHIFT_BITS-1:0] r_rx_shift;
  logic [3:0]            r_rx_idx;
  logic [7:0]            r_data_out;
  logic                  r_rx_busy;
  logic                  r_done;
  logic                  w_rx_fall;
  logic                  w_rx_run;
  logic                  w_rx_tick;
  logic                  w_rx_frame_ok;

  assign w_rx_fall    = r_rx_prev && !r_rx_sync;
  assign w_rx_run     = (r_rx_state != RX_IDLE);
  assign bus.data_out = r_data_out;
  assign bus.rx_busy  = r_rx_busy;
  assign bus.done     = r_done;

`ifdef UART_PARITY_EN
  assign w_rx_frame_ok = r_rx_sync && (^r_rx_shift);
`else
  assign w_rx_frame_ok = r_rx_sync;
`endif

  // Timer is loaded with half a period so every later tick lands mid-bit.
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk_100Mhz (clk_100Mhz),
    .rst_n      (rst_n),
    .en         (w_rx_run),
    .load       (!w_rx_run && w_rx_fall),
    .load_half  (1'b1),
    .tick       (w_rx_tick)
  );

  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_shift <= '0;
      r_rx_idx   <= '0;
      r_data_out <= '0;
      r_rx_busy  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_rx_state)
        RX_IDLE: if (w_rx_fall) begin
          r_rx_busy  <= 1'b1;
          r_rx_state <= RX_START;
        end
        RX_START: if (w_rx_tick) begin
          if (r_rx_sync) begin
            r_rx_busy  <= 1'b0;
            r_rx_state <= RX_IDLE;
          end else begin
            r_rx_idx   <= '0;
            r_rx_state <= RX_DATA;
          end
        end
        RX_DATA: if (w_rx_tick) begin
          r_rx_shift <= {r_rx_sync, r_rx_shift[SHIFT_BITS-1:1]};
          if (r_rx_idx == c_LAST_IDX) r_rx_state <= RX_STOP;
          else                        r_rx_idx   <= r_rx_idx + 4'd1;
        end
        RX_STOP: if (w_rx_tick) begin
          if (w_rx_frame_ok) begin
            r_data_out <= r_rx_shift[7:0];
            r_done     <= 1'b1;
          end
          r_rx_busy  <= 1'b0;
          r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_phy.sv
// +------------------------------------------------------------------+
// | tb_uart_phy : scoreboard bench for uart_phy with a frame model    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_uart_phy;
  import uart_pkg::*;

  localparam int N  = 16;
  localparam int FB = FRAME_BITS;

  logic clk_100Mhz = 1'b0;
  logic rst_n      = 1'b0;
  always #5 clk_100Mhz = ~clk_100Mhz;

  uart_phy_if bus();
  logic tx_w;
  logic rx_line;
  logic rx_drv   = 1'b1;
  logic loopback = 1'b0;
  assign rx_line = loopback ? tx_w : rx_drv;

  uart_phy #(.CLK_FREQ_HZ(1600), .BAUD(100), .CLKS_PER_BIT(N)) dut (
    .clk_100Mhz (clk_100Mhz),
    .rst_n      (rst_n),
    .bus        (bus),
    .tx         (tx_w),
    .rx         (rx_line)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Line-level view of a frame: start, data LSB first, optional parity, stop.
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0)      return 1'b0;
    if (k <= 8)      return d[k-1];
    if (k == FB - 1) return 1'b1;
    return ~(^d);
  endfunction

  always @(negedge clk_100Mhz) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        chk("rx_data", {24'd0, bus.data_out}, {24'd0, exp_q.pop_front()});
        chk("rx_busy_at_done", {31'd0, bus.rx_busy}, 32'd0);
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit hold, input bit expect_rx);
    @(negedge clk_100Mhz);
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    #1 chk("tx_busy_same_cycle", {31'd0, bus.tx_busy}, 32'd1);
    if (expect_rx) begin
      exp_q.push_back(d);
      last_good = d;
    end
    @(posedge clk_100Mhz);
    #1;
    if (!hold) bus.tx_start = 1'b0;
    bus.tx_data = ~d;
    repeat (N / 2) @(posedge clk_100Mhz);
    #1;
    for (int k = 0; k < FB; k++) begin
      chk($sformatf("tx_bit%0d_of_%02h", k, d), {31'd0, tx_w}, {31'd0, frame_bit(d, k)});
      if (k != FB - 1) begin
        repeat (N) @(posedge clk_100Mhz);
        #1;
      end
    end
    repeat (N / 2 - 1) @(posedge clk_100Mhz);
    #1 chk("tx_busy_last_cycle", {31'd0, bus.tx_busy}, 32'd1);
    @(posedge clk_100Mhz);
    #1 chk("tx_busy_dropped", {31'd0, bus.tx_busy}, 32'd0);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop_v);
    @(negedge clk_100Mhz);
    for (int k = 0; k < FB; k++) begin
      rx_drv = (k == FB - 1) ? stop_v : frame_bit(d, k);
      repeat (N) @(negedge clk_100Mhz);
    end
    rx_drv = 1'b1;
    repeat (2 * N) @(negedge clk_100Mhz);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * FB * N && exp_q.size() != 0; i++) @(negedge clk_100Mhz);
    chk("rx_queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         bad;
    logic [7:0] sensor_msg [5];
    sensor_msg = '{8'h53, 8'h3A, 8'h32, 8'h35, 8'h0A};
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;

    repeat (5) @(negedge clk_100Mhz);
    chk("rst_tx",       {31'd0, tx_w},        32'd1);
    chk("rst_tx_busy",  {31'd0, bus.tx_busy}, 32'd0);
    chk("rst_done",     {31'd0, bus.done},    32'd0);
    chk("rst_rx_busy",  {31'd0, bus.rx_busy}, 32'd0);
    chk("rst_data_out", {24'd0, bus.data_out}, 32'd0);
    rst_n = 1'b1;

    bad = 0;
    repeat (500) begin
      @(negedge clk_100Mhz);
      if (tx_w !== 1'b1 || bus.rx_busy !== 1'b0 || bus.tx_busy !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 32'd0);

    // Sensor string over loopback, then random bytes back-to-back.
    loopback = 1'b1;
    foreach (sensor_msg[i]) send(sensor_msg[i], 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) send(8'($urandom_range(0, 255)), 1'b0, 1'b1);
    drain();
    chk("data_out_last_loopback", {24'd0, bus.data_out}, {24'd0, last_good});

    loopback = 1'b0;
    @(negedge clk_100Mhz);
    rx_drv = 1'b0;
    repeat (3) @(negedge clk_100Mhz);
    rx_drv = 1'b1;
    chk("glitch_busy_rise", {31'd0, bus.rx_busy}, 32'd1);
    repeat (N) @(negedge clk_100Mhz);
    chk("glitch_busy_fall", {31'd0, bus.rx_busy}, 32'd0);
    chk("glitch_data_kept", {24'd0, bus.data_out}, {24'd0, last_good});

    drive_frame(8'h4C, 1'b0);
    chk("framing_err_data_kept", {24'd0, bus.data_out}, {24'd0, last_good});
    exp_q.push_back(8'h31);
    last_good = 8'h31;
    drive_frame(8'h31, 1'b1);
    drain();
    chk("after_framing_err", {24'd0, bus.data_out}, 32'h31);

    for (int i = 0; i < 4; i++) begin
      logic [7:0] r;
      r = 8'($urandom_range(0, 255));
      exp_q.push_back(r);
      last_good = r;
      drive_frame(r, 1'b1);
    end
    drain();

    // A single rising edge held for three frame times sends one frame only.
    loopback = 1'b1;
    send(8'hA5, 1'b1, 1'b1);
    bad = 0;
    repeat (2 * FB * N) begin
      @(negedge clk_100Mhz);
      if (tx_w !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
    end
    chk("hold_no_retrigger", bad, 32'd0);
    bus.tx_start = 1'b0;
    drain();

    @(negedge clk_100Mhz);
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b1;
    @(posedge clk_100Mhz);
    #1 bus.tx_start = 1'b0;
    repeat (3 * N) @(posedge clk_100Mhz);
    #3 chk("midframe_tx_low", {31'd0, tx_w}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midframe_rst_tx",      {31'd0, tx_w},        32'd1);
    chk("midframe_rst_busy",    {31'd0, bus.tx_busy}, 32'd0);
    chk("midframe_rst_rx_busy", {31'd0, bus.rx_busy}, 32'd0);
    repeat (3) @(negedge clk_100Mhz);
    rst_n = 1'b1;
    bad = 0;
    repeat (2 * FB * N) begin
      @(negedge clk_100Mhz);
      if (tx_w !== 1'b1) bad++;
    end
    chk("post_reset_line_idle", bad, 32'd0);
    chk("post_reset_data_out", {24'd0, bus.data_out}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
